seq_datapath: RTL and testbench

Self-sequencing, parametrised successor to the Phase 1 bus datapath. The same single-bus organisation (GPR file, PC, IR, RY, 2×BITS RZ, MAR, MDR, HI, LO) is driven by an internal step sequencer instead of externally supplied per-register strobes. It fetches, decodes and executes instructions against an external word-addressed memory through a req/ready handshake. It sits between the testbench/top level and a memory model and is the first block to run programs without cycle-by-cycle control from the bench.

---
 rtl/seq_datapath_pkg.sv | 72 +++++++
 rtl/seq_datapath_control.sv | 125 ++++++++++++
 rtl/seq_datapath.sv | 174 +++++++++++++++++
 tb/tb_seq_datapath.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_datapath_pkg.sv
// seq_datapath shared types: opcodes, sequencer states, bus/load bundles
// and instruction field positions derived from BITS/REGISTERS.
package seq_datapath_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_ROR  = 5'd6;
  localparam logic [4:0] OP_ROL  = 5'd7;
  localparam logic [4:0] OP_MUL  = 5'd8;
  localparam logic [4:0] OP_DIV  = 5'd9;
  localparam logic [4:0] OP_NEG  = 5'd10;
  localparam logic [4:0] OP_NOT  = 5'd11;
  localparam logic [4:0] OP_LD   = 5'd12;
  localparam logic [4:0] OP_ST   = 5'd13;
  localparam logic [4:0] OP_ADDI = 5'd14;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7,
    S_HALTED, S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    G_RA, G_RB, G_RC
  } gsel_e;

  typedef struct packed {
    logic pc;
    logic mdr;
    logic gpr;
    logic imm;
    logic rz;
  } bsel_t;

  typedef struct packed {
    logic mar;
    logic pc;
    logic mdr_mem;
    logic mdr_bus;
    logic ir;
    logic ry;
    logic rz;
    logic gpr;
    logic hilo;
  } ld_t;

  function automatic int ra_lsb(int bits, int rw);
    return bits - 5 - rw;
  endfunction

  function automatic int rb_lsb(int bits, int rw);
    return bits - 5 - 2 * rw;
  endfunction

  function automatic int rc_lsb(int bits, int rw);
    return bits - 5 - 3 * rw;
  endfunction

  function automatic int c_msb(int bits, int rw);
    return bits - 6 - 2 * rw;
  endfunction

  function automatic logic op_legal(logic [4:0] op);
    return (op <= OP_ADDI) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/seq_datapath_control.sv
// seq_control: step sequencer, decode and one-hot bus/load enables
// for the single-bus datapath.
module seq_control
  import seq_datapath_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       mem_ready_i,
  input  logic [4:0] op_i,
  output state_e     state_o,
  output bsel_t      bsel_o,
  output gsel_e      gsel_o,
  output ld_t        ld_o,
  output logic       mem_req_o,
  output logic       mem_we_o
);

  state_e state_q, state_d;
  logic   is_imm, is_mem, is_ld, is_hilo;

  assign is_ld   = (op_i == OP_LD);
  assign is_mem  = is_ld || (op_i == OP_ST);
  assign is_imm  = is_mem || (op_i == OP_ADDI);
  assign is_hilo = (op_i == OP_MUL) || (op_i == OP_DIV);
  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bsel_o    = '0;
    gsel_o    = G_RB;
    ld_o      = '0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_T0;
      S_T0: begin
        bsel_o.pc = 1'b1;
        ld_o.mar  = 1'b1;
        ld_o.pc   = 1'b1;
        state_d   = S_T1;
      end
      S_T1: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ld_o.mdr_mem = 1'b1;
          state_d      = S_T2;
        end
      end
      S_T2: begin
        bsel_o.mdr = 1'b1;
        ld_o.ir    = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        if (op_i == OP_HALT) begin
          state_d = S_HALTED;
        end else if (!op_legal(op_i)) begin
          state_d = S_FAULT;
        end else begin
          bsel_o.gpr = 1'b1;
          ld_o.ry    = 1'b1;
          state_d    = S_T4;
        end
      end
      S_T4: begin
        if (is_imm) begin
          bsel_o.imm = 1'b1;
        end else begin
          bsel_o.gpr = 1'b1;
          gsel_o     = G_RC;
        end
        ld_o.rz = 1'b1;
        state_d = S_T5;
      end
      S_T5: begin
        bsel_o.rz = 1'b1;
        if (is_mem) begin
          ld_o.mar = 1'b1;
          state_d  = S_T6;
        end else begin
          ld_o.hilo = is_hilo;
          ld_o.gpr  = !is_hilo;
          gsel_o    = G_RA;
          state_d   = S_T0;
        end
      end
      S_T6: begin
        if (is_ld) begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ld_o.mdr_mem = 1'b1;
            state_d      = S_T7;
          end
        end else begin
          bsel_o.gpr   = 1'b1;
          gsel_o       = G_RA;
          ld_o.mdr_bus = 1'b1;
          state_d      = S_T7;
        end
      end
      S_T7: begin
        if (is_ld) begin
          bsel_o.mdr = 1'b1;
          ld_o.gpr   = 1'b1;
          gsel_o     = G_RA;
          state_d    = S_T0;
        end else begin
          mem_req_o = 1'b1;
          mem_we_o  = 1'b1;
          if (mem_ready_i) state_d = S_T0;
        end
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/seq_datapath.sv
// seq_datapath: self-sequencing single-bus datapath (GPRs, PC, IR, RY,
// RZ, MAR, MDR, HI, LO) fetching and executing from word-addressed memory.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16,
  parameter int ADDR_BITS = BITS,
  localparam int RW       = $clog2(REGISTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [BITS-1:0]      mem_wdata,
  input  logic [BITS-1:0]      mem_rdata,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [BITS-1:0]      bus,
  output logic [BITS-1:0]      pc_out,
  output logic [BITS-1:0]      ir_out,
  input  logic [RW-1:0]        dbg_sel,
  output logic [BITS-1:0]      dbg_data
);

  localparam int RA = ra_lsb(BITS, RW);
  localparam int RB = rb_lsb(BITS, RW);
  localparam int RC = rc_lsb(BITS, RW);
  localparam int CM = c_msb(BITS, RW);
  localparam int SW = $clog2(BITS);

  logic [BITS-1:0]   pc_q, ir_q, ry_q, mar_q, mdr_q, hi_q, lo_q;
  logic [2*BITS-1:0] rz_q;
  logic [BITS-1:0]   gpr_q [REGISTERS];

  state_e          state;
  bsel_t           bsel;
  gsel_e           gsel;
  ld_t             ld;
  logic [4:0]      op;
  logic [RW-1:0]   ra, rb, rc, gidx;
  logic [BITS-1:0] imm, bus_v;

  assign op  = ir_q[BITS-1 -: 5];
  assign ra  = ir_q[RA +: RW];
  assign rb  = ir_q[RB +: RW];
  assign rc  = ir_q[RC +: RW];
  assign imm = {{(BITS-1-CM){ir_q[CM]}}, ir_q[CM:0]};

  seq_control u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .mem_ready_i(mem_ready),
    .op_i       (op),
    .state_o    (state),
    .bsel_o     (bsel),
    .gsel_o     (gsel),
    .ld_o       (ld),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we)
  );

  always_comb begin
    gidx = rb;
    unique case (gsel)
      G_RA:    gidx = ra;
      G_RC:    gidx = rc;
      default: gidx = rb;
    endcase
  end

  always_comb begin
    bus_v = '0;
    unique case (1'b1)
      bsel.pc:  bus_v = pc_q;
      bsel.mdr: bus_v = mdr_q;
      bsel.gpr: bus_v = gpr_q[gidx];
      bsel.imm: bus_v = imm;
      bsel.rz:  bus_v = rz_q[BITS-1:0];
      default:  bus_v = '0;
    endcase
  end

  logic [BITS-1:0]          a, b, alu_hi, alu_lo;
  logic [SW-1:0]            sh;
  logic [2*BITS-1:0]        dbl_r, dbl_l;
  logic signed [2*BITS-1:0] prod;
  logic signed [BITS-1:0]   quo, rem;

  assign a = ry_q;
  assign b = bus_v;

  always_comb begin
    sh    = SW'(b % BITS);
    dbl_r = {a, a} >> sh;
    dbl_l = {a, a} << sh;
    prod  = $signed({{BITS{a[BITS-1]}}, a}) * $signed({{BITS{b[BITS-1]}}, b});
    quo   = '0;
    rem   = '0;
    if (b != '0) begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end
    alu_hi = '0;
    alu_lo = a + b;
    case (op)
      OP_SUB: alu_lo = a - b;
      OP_AND: alu_lo = a & b;
      OP_OR:  alu_lo = a | b;
      OP_SHR: alu_lo = a >> sh;
      OP_SHL: alu_lo = a << sh;
      OP_ROR: alu_lo = dbl_r[BITS-1:0];
      OP_ROL: alu_lo = dbl_l[2*BITS-1:BITS];
      OP_MUL: {alu_hi, alu_lo} = prod;
      OP_DIV: begin
        // divide by zero leaves the dividend in HI and all ones in LO
        if (b == '0) {alu_hi, alu_lo} = {a, {BITS{1'b1}}};
        else         {alu_hi, alu_lo} = {rem, quo};
      end
      OP_NEG: alu_lo = '0 - a;
      OP_NOT: alu_lo = ~a;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      ry_q  <= '0;
      rz_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (ld.pc)      pc_q  <= pc_q + BITS'(1);
      if (ld.mar)     mar_q <= bus_v;
      if (ld.ir)      ir_q  <= bus_v;
      if (ld.ry)      ry_q  <= bus_v;
      if (ld.rz)      rz_q  <= {alu_hi, alu_lo};
      if (ld.mdr_mem) mdr_q <= mem_rdata;
      if (ld.mdr_bus) mdr_q <= bus_v;
      if (ld.hilo) begin
        hi_q <= rz_q[2*BITS-1:BITS];
        lo_q <= bus_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGISTERS; i++) gpr_q[i] <= '0;
    end else if (ld.gpr) begin
      gpr_q[gidx] <= bus_v;
    end
  end

  assign mem_addr  = mar_q[ADDR_BITS-1:0];
  assign mem_wdata = mdr_q;
  assign busy      = !(state inside {S_IDLE, S_HALTED, S_FAULT});
  assign halted    = (state == S_HALTED);
  assign fault     = (state == S_FAULT);
  assign bus       = bus_v;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign dbg_data  = gpr_q[dbg_sel];

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath: vector table of small programs plus
// hand sequences for memory waits, faults and mid-handshake reset.
module tb_seq_datapath;

  localparam logic [4:0] O_ADD  = 5'd0;
  localparam logic [4:0] O_SUB  = 5'd1;
  localparam logic [4:0] O_AND  = 5'd2;
  localparam logic [4:0] O_OR   = 5'd3;
  localparam logic [4:0] O_SHR  = 5'd4;
  localparam logic [4:0] O_SHL  = 5'd5;
  localparam logic [4:0] O_ROR  = 5'd6;
  localparam logic [4:0] O_ROL  = 5'd7;
  localparam logic [4:0] O_MUL  = 5'd8;
  localparam logic [4:0] O_DIV  = 5'd9;
  localparam logic [4:0] O_NEG  = 5'd10;
  localparam logic [4:0] O_NOT  = 5'd11;
  localparam logic [4:0] O_LD   = 5'd12;
  localparam logic [4:0] O_ST   = 5'd13;
  localparam logic [4:0] O_ADDI = 5'd14;
  localparam logic [4:0] O_HALT = 5'd31;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, halted, fault;
  logic [31:0] bus, pc_out, ir_out, dbg_data;
  logic [3:0]  dbg_sel = 4'd0;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [64];
  logic [31:0] dmem [256];
  int          waits = 0;
  int          wcnt = 0;

  always #5 clk = ~clk;

  seq_datapath dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy     (busy),
    .halted   (halted),
    .fault    (fault),
    .bus      (bus),
    .pc_out   (pc_out),
    .ir_out   (ir_out),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  assign mem_ready = mem_req && (wcnt >= waits);
  assign mem_rdata = (mem_addr[7:6] == 2'd0) ? prog[mem_addr[5:0]]
                                             : dmem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      wcnt <= 0;
      if (mem_we) dmem[mem_addr[7:0]] <= mem_wdata;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  function automatic logic [31:0] ir_r(logic [4:0] op, int ra, int rb, int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  function automatic logic [31:0] ir_i(logic [4:0] op, int ra, int rb, int c);
    return {op, 4'(ra), 4'(rb), 19'(c)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = ir_r(O_HALT, 0, 0, 0);
  endtask

  task automatic rd(int r, output logic [31:0] v);
    dbg_sel = 4'(r);
    #1;
    v = dbg_data;
  endtask

  // cycles counted from the edge that enters T0 to HALTED/FAULT
  task automatic run(string name, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(halted || fault) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, {31'd0, halted | fault}, 32'd1);
  endtask

  typedef struct {
    logic [4:0]  op;
    int          a;
    int          b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] v;

    vt[0]  = '{O_ADD,  5,       -3,   32'h0000_0002};
    vt[1]  = '{O_SUB,  5,        7,   32'hFFFF_FFFE};
    vt[2]  = '{O_AND,  'h0F0F,   'hFF, 32'h0000_000F};
    vt[3]  = '{O_OR,   'h0F00,   'hF0, 32'h0000_0FF0};
    vt[4]  = '{O_SHR,  -16,      4,   32'h0FFF_FFFF};
    vt[5]  = '{O_SHL,  3,        31,  32'h8000_0000};
    vt[6]  = '{O_ROR,  1,        1,   32'h8000_0000};
    vt[7]  = '{O_ROL,  'h12345,  8,   32'h0123_4500};
    vt[8]  = '{O_SHR,  'h100,    36,  32'h0000_0010};
    vt[9]  = '{O_NEG,  5,        0,   32'hFFFF_FFFB};
    vt[10] = '{O_NOT,  5,        0,   32'hFFFF_FFFA};
    vt[11] = '{O_ADDI, 5,        -100, 32'hFFFF_FFA1};
    vt[12] = '{O_ROR,  'h1234,   32,  32'h0000_1234};

    for (int i = 0; i < 256; i++) dmem[i] = '0;
    clear_prog();
    do_reset();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_bus", bus, 32'd0);
    check("rst_pc", pc_out, 32'd0);

    // ADDI r1,r0,5 ; HALT
    prog[0] = ir_i(O_ADDI, 1, 0, 5);
    run("addi_halt", cyc);
    check("addi_halt_cycles", 32'(cyc), 32'd10);
    rd(1, v);
    check("addi_r1", v, 32'd5);
    check("addi_pc", pc_out, 32'd2);
    check("addi_ir", ir_out, 32'hF800_0000);
    check("addi_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("halt_ignores_start", pc_out, 32'd2);
    check("halt_sticky", {31'd0, halted}, 32'd1);
    do_reset();
    check("rerst_halted", {31'd0, halted}, 32'd0);
    check("rerst_pc", pc_out, 32'd0);
    rd(1, v);
    check("rerst_r1", v, 32'd0);

    for (int i = 0; i < 13; i++) begin
      clear_prog();
      prog[0] = ir_i(O_ADDI, 1, 0, vt[i].a);
      prog[1] = ir_i(O_ADDI, 2, 0, vt[i].b);
      if (vt[i].op == O_ADDI) prog[2] = ir_i(O_ADDI, 3, 1, vt[i].b);
      else                    prog[2] = ir_r(vt[i].op, 3, 1, 2);
      do_reset();
      run($sformatf("vec%0d", i), cyc);
      rd(3, v);
      check($sformatf("vec%0d_r3", i), v, vt[i].exp);
    end

    clear_prog();
    prog[0] = ir_i(O_ADDI, 2, 0, 7);
    prog[1] = ir_i(O_ADDI, 3, 0, -3);
    prog[2] = ir_r(O_MUL, 0, 2, 3);
    do_reset();
    run("mul", cyc);
    check("mul_cycles", 32'(cyc), 32'd22);
    check("mul_hi", dut.hi_q, 32'hFFFF_FFFF);
    check("mul_lo", dut.lo_q, 32'hFFFF_FFEB);

    clear_prog();
    prog[0] = ir_i(O_ADDI, 2, 0, 7);
    prog[1] = ir_r(O_DIV, 0, 2, 0);
    do_reset();
    run("div0", cyc);
    check("div0_lo", dut.lo_q, 32'hFFFF_FFFF);
    check("div0_hi", dut.hi_q, 32'h0000_0007);

    clear_prog();
    prog[0] = ir_i(O_ADDI, 2, 0, -7);
    prog[1] = ir_i(O_ADDI, 3, 0, 2);
    prog[2] = ir_r(O_DIV, 0, 2, 3);
    do_reset();
    run("divneg", cyc);
    check("divneg_lo", dut.lo_q, 32'hFFFF_FFFD);
    check("divneg_hi", dut.hi_q, 32'hFFFF_FFFF);

    clear_prog();
    prog[0] = ir_i(O_ADDI, 2, 0, 7);
    prog[1] = ir_i(O_ST, 2, 0, 'h40);
    prog[2] = ir_i(O_LD, 4, 0, 'h40);
    do_reset();
    waits = 3;
    run("stld", cyc);
    waits = 0;
    check("stld_cycles", 32'(cyc), 32'd44);
    check("stld_mem40", dmem[64], 32'd7);
    rd(4, v);
    check("stld_r4", v, 32'd7);

    clear_prog();
    prog[0] = ir_i(O_ADDI, 6, 0, 31);
    prog[1] = ir_i(O_ADDI, 7, 0, 1);
    prog[2] = ir_r(O_SHL, 5, 7, 6);
    prog[3] = ir_i(O_ADDI, 5, 5, 1);
    prog[4] = ir_i(O_ADDI, 10, 0, 33);
    prog[5] = ir_r(O_ROL, 9, 5, 7);
    prog[6] = ir_r(O_SHR, 11, 5, 10);
    do_reset();
    run("rot", cyc);
    rd(5, v);
    check("rot_r5", v, 32'h8000_0001);
    rd(9, v);
    check("rol_r9", v, 32'h0000_0003);
    rd(11, v);
    check("shr33_r11", v, 32'h4000_0000);

    clear_prog();
    prog[0] = {5'd20, 27'd0};
    do_reset();
    run("illegal", cyc);
    check("illegal_cycles", 32'(cyc), 32'd4);
    check("illegal_fault", {31'd0, fault}, 32'd1);
    check("illegal_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("fault_sticky", {31'd0, fault}, 32'd1);
    check("fault_pc", pc_out, 32'd1);
    check("fault_ir", ir_out, 32'hA000_0000);
    do_reset();
    check("fault_cleared", {31'd0, fault}, 32'd0);

    clear_prog();
    prog[0] = ir_i(O_ADDI, 1, 0, 9);
    do_reset();
    waits = 100;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t1_mem_req", {31'd0, mem_req}, 32'd1);
    check("t1_pc", pc_out, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_pc", pc_out, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    waits = 0;
    run("refetch", cyc);
    check("refetch_cycles", 32'(cyc), 32'd10);
    rd(1, v);
    check("refetch_r1", v, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
